lc3_seq_alu: RTL and testbench
==============================

Name: lc3_seq_alu

Overview:
Parametrised, multi-cycle successor to the LC-3 datapath ALU. It adds 3-bit op select, XOR/OR, iterative multiply and iterative arithmetic right shift, a valid/ready handshake on both sides, registered NZP/C flags, and a held result. It sits between the register file/SR2 mux and the bus gate. The control FSM issues an op, then waits on OUT_VALID before gating ALU_OUT.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 4..32.
SHW, 4, width of the shift-amount field taken from B_IN[SHW-1:0]; 2**SHW <= WIDTH.

Ports:
Clk  in  1  system clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
A_IN  in  WIDTH  operand A (SR1 side).
B_IN  in  WIDTH  operand B (SR2MUX side); B_IN[SHW-1:0] is the shift amount for SRA.
ALUK  in  3  op select: 000 ADD, 001 AND, 010 NOT A, 011 PASS A, 100 XOR, 101 OR, 110 MUL, 111 SRA.
IN_VALID  in  1  operands/op valid.
IN_READY  out  1  block can accept an op.
ALU_OUT  out  WIDTH  registered result.
N_OUT, Z_OUT, P_OUT  out  1 each  registered condition codes of ALU_OUT.
C_OUT  out  1  carry out of ADD; 0 for every other op.
OUT_VALID  out  1  ALU_OUT/flags valid.
OUT_READY  in  1  consumer takes result.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset forces IDLE. Reset also forces ALU_OUT=0, N/P/C=0, Z=1, OUT_VALID=0 and the internal counter=0. Reset wins over every other event, including mid-BUSY and mid-DONE; any in-flight op is discarded.
- IN_READY = (state==IDLE). OUT_VALID = (state==DONE). The block never holds two ops; there is no overlap.
- Accept: IN_VALID & IN_READY at a rising edge captures A_IN, B_IN and ALUK. Inputs are don't-care afterwards.
- Single-cycle ops (ADD, AND, NOT, PASS, XOR, OR, and SRA with amount 0): result and flags are registered on the accept edge, and the FSM goes IDLE->DONE. OUT_VALID rises in the following cycle, giving latency 1.
- ADD: result = (A+B) mod 2**WIDTH. C = bit WIDTH of the (WIDTH+1)-bit sum. No overflow flag.
- MUL: unsigned shift-add over WIDTH iterations, one bit of B per cycle, LSB first. Result = low WIDTH bits of A*B. FSM is IDLE->BUSY, stays in BUSY for exactly WIDTH cycles, then moves to DONE. OUT_VALID is first high WIDTH+1 cycles after the accept edge.
- SRA: amount n = B[SHW-1:0]. Shift A right arithmetically one bit per cycle, replicating the sign. BUSY lasts n cycles, then DONE; OUT_VALID is first high n+1 cycles after accept. n=0 behaves as a single-cycle op.
- Flags are computed from the final result on the same edge ALU_OUT is loaded: N = ALU_OUT[WIDTH-1], Z = (ALU_OUT==0), P = !N & !Z. Exactly one of N/Z/P is high after reset or any completed op.
- In BUSY, ALU_OUT and the flags hold their previous values. Partial products are not visible.
- DONE: ALU_OUT and flags are held stable while OUT_READY=0, for any number of cycles. An edge with OUT_READY=1 moves DONE->IDLE, OUT_VALID drops the next cycle, and ALU_OUT/flags keep their value until the next op completes.
- IN_VALID in BUSY/DONE is ignored (IN_READY=0). The next accept is possible in the cycle after DONE->IDLE, so single-cycle ops sustain one result per 2 cycles under OUT_READY=1.
- ALUK values are fully decoded with no default; all 8 are legal.

Test Plan:
1. Reset held for 2 cycles, then released -> ALU_OUT=0x0000, Z=1, N=P=C=0, OUT_VALID=0, IN_READY=1.
2. WIDTH=16: ADD A=0x7FFF, B=0x0001 -> next cycle ALU_OUT=0x8000, N=1, C=0. ADD A=0xFFFF, B=0x0001 -> ALU_OUT=0x0000, Z=1, C=1. XOR A=0xF0F0, B=0xFF00 -> 0x0FF0, P=1.
3. MUL A=0x0012, B=0x0034 -> IN_READY low for 17 cycles; OUT_VALID first high exactly 17 cycles after accept; ALU_OUT=0x03A8, P=1. MUL A=0x0100, B=0x0100 -> 0x0000, Z=1.
4. SRA A=0x8000, B=0x0004 -> OUT_VALID 5 cycles after accept, ALU_OUT=0xF800, N=1. SRA A=0x1234, B=0x0000 -> OUT_VALID next cycle, ALU_OUT=0x1234.
5. Backpressure: complete NOT A=0x00FF, hold OUT_READY=0 for 10 cycles while toggling IN_VALID, A_IN and B_IN -> ALU_OUT stays 0xFF00, N=1, IN_READY=0. Raise OUT_READY -> OUT_VALID low the next cycle and IN_READY=1.
6. Assert Reset during cycle 8 of a MUL -> next cycle IDLE, OUT_VALID=0, ALU_OUT=0, Z=1. A following ADD 0x0002+0x0003 returns 0x0005 with latency 1.

Source files
------------

// File: rtl/lc3_seq_alu_if.sv
// Operand/result bundle between the SR1/SR2MUX side, the ALU and the bus gate.
// Carries the op request (valid/ready) and the held result with its condition codes.
// The master drives operands and takes results; the slave is the ALU.
interface lc3_seq_alu_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [2:0]       aluk;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_out;
    logic             n_out;
    logic             z_out;
    logic             p_out;
    logic             c_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a_in, b_in, aluk, in_valid, out_ready,
        input  in_ready, alu_out, n_out, z_out, p_out, c_out, out_valid
    );

    modport slave (
        input  a_in, b_in, aluk, in_valid, out_ready,
        output in_ready, alu_out, n_out, z_out, p_out, c_out, out_valid
    );
endinterface

// File: rtl/lc3_seq_alu.sv
// Multi-cycle LC-3 ALU: ADD/AND/NOT/PASS/XOR/OR in one cycle, iterative MUL and SRA.
// Latency: 1 cycle for simple ops and SRA by 0, WIDTH+1 for MUL, n+1 for SRA by n.
// Backpressure: one op in flight; result and flags held in DONE until out_ready is seen.
module lc3_seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic         clk,
    input  logic         reset,
    lc3_seq_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SRA  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] opa_q;    // multiplicand for MUL, shifting value for SRA
    logic [WIDTH-1:0] opb_q;    // multiplier bits, consumed LSB first
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] alu_out_q;
    logic             n_q;
    logic             z_q;
    logic             p_q;
    logic             c_q;

    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] imm_res;
    logic             imm_c;
    logic             imm_multi;
    logic [WIDTH-1:0] mul_step;
    logic [WIDTH-1:0] sra_step;
    logic [WIDTH-1:0] busy_res;

    function automatic logic [2:0] nzp(input logic [WIDTH-1:0] r);
        logic zero;
        zero = (r == '0);
        return {r[WIDTH-1], zero, !r[WIDTH-1] && !zero};
    endfunction

    assign shamt = bus.b_in[SHW-1:0];
    assign sum   = {1'b0, bus.a_in} + {1'b0, bus.b_in};

    // Result of every op that can finish on the accept edge, straight from the inputs.
    always_comb begin
        imm_res   = '0;
        imm_c     = 1'b0;
        imm_multi = 1'b0;
        case (bus.aluk)
            OP_ADD: begin
                imm_res = sum[WIDTH-1:0];
                imm_c   = sum[WIDTH];
            end
            OP_AND:  imm_res = bus.a_in & bus.b_in;
            OP_NOT:  imm_res = ~bus.a_in;
            OP_PASS: imm_res = bus.a_in;
            OP_XOR:  imm_res = bus.a_in ^ bus.b_in;
            OP_OR:   imm_res = bus.a_in | bus.b_in;
            OP_MUL:  imm_multi = 1'b1;
            OP_SRA: begin
                imm_res   = bus.a_in;
                imm_multi = (shamt != '0);
            end
        endcase
    end

    assign mul_step = acc_q + (opb_q[0] ? opa_q : '0);
    assign sra_step = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
    assign busy_res = (op_q == OP_MUL) ? mul_step : sra_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            alu_out_q <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b1;
            p_q       <= 1'b0;
            c_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.aluk;
                        opa_q <= bus.a_in;
                        opb_q <= bus.b_in;
                        acc_q <= '0;
                        if (imm_multi) begin
                            cnt_q <= (bus.aluk == OP_MUL) ? CW'(WIDTH)
                                                          : {{(CW-SHW){1'b0}}, shamt};
                            state <= BUSY;
                        end else begin
                            alu_out_q         <= imm_res;
                            {n_q, z_q, p_q}   <= nzp(imm_res);
                            c_q               <= imm_c;
                            state             <= DONE;
                        end
                    end
                end
                BUSY: begin
                    // One iteration per cycle; the visible result only changes on the last one.
                    acc_q <= mul_step;
                    opa_q <= (op_q == OP_MUL) ? (opa_q << 1) : sra_step;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        alu_out_q       <= busy_res;
                        {n_q, z_q, p_q} <= nzp(busy_res);
                        c_q             <= 1'b0;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.alu_out   = alu_out_q;
    assign bus.n_out     = n_q;
    assign bus.z_out     = z_q;
    assign bus.p_out     = p_q;
    assign bus.c_out     = c_q;
endmodule

// File: tb/tb_lc3_seq_alu.sv
// Directed bench for lc3_seq_alu at WIDTH=16, SHW=4.
// Latency: checks exact OUT_VALID timing per op.
// Backpressure: holds out_ready low while toggling inputs, then releases.
module tb_lc3_seq_alu;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    lc3_seq_alu_if #(.WIDTH(16)) bus ();

    lc3_seq_alu #(.WIDTH(16), .SHW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for exactly one accept edge; leaves the sample point 1 after that edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.aluk     = op;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // cyc = cycles after accept until OUT_VALID seen; low = of those, cycles with IN_READY low.
    task automatic wait_done(output int cyc, output int low);
        cyc = 1;
        low = bus.in_ready ? 0 : 1;
        while (!bus.out_valid && cyc < 100) begin
            tick();
            cyc++;
            if (!bus.in_ready) low++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        total++; if (bus.alu_out !== 16'h0000) begin bad++; $display("FAIL reset_alu_out got=%h want=0000", bus.alu_out); end
        total++; if ({bus.n_out, bus.z_out, bus.p_out, bus.c_out} !== 4'b0100) begin bad++; $display("FAIL reset_flags nzpc got=%b want=0100", {bus.n_out, bus.z_out, bus.p_out, bus.c_out}); end
        total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL reset_hs ov/ir got=%b want=01", {bus.out_valid, bus.in_ready}); end
    endtask

    task automatic test_single();
        logic [2:0]  ops  [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b011, 3'b010, 3'b000};
        logic [15:0] as   [8] = '{16'h7FFF, 16'hFFFF, 16'hF0F0, 16'h0F0F, 16'h0F00, 16'h8001, 16'h1234, 16'h1234};
        logic [15:0] bs   [8] = '{16'h0001, 16'h0001, 16'hFF00, 16'h00FF, 16'h00F0, 16'hFFFF, 16'h0000, 16'h4321};
        logic [15:0] res  [8] = '{16'h8000, 16'h0000, 16'h0FF0, 16'h000F, 16'h0FF0, 16'h8001, 16'hEDCB, 16'h5555};
        logic [3:0]  flg  [8] = '{4'b1000, 4'b0101, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010};
        int cyc, low;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(cyc, low);
            total++; if (cyc !== 1) begin bad++; $display("FAIL single_latency[%0d] got=%0d want=1", i, cyc); end
            total++; if (bus.alu_out !== res[i]) begin bad++; $display("FAIL single_result[%0d] got=%h want=%h", i, bus.alu_out, res[i]); end
            total++; if ({bus.n_out, bus.z_out, bus.p_out, bus.c_out} !== flg[i]) begin bad++; $display("FAIL single_flags[%0d] nzpc got=%b want=%b", i, {bus.n_out, bus.z_out, bus.p_out, bus.c_out}, flg[i]); end
            tick();
        end
    endtask

    task automatic test_mul();
        logic [15:0] as  [3] = '{16'h0012, 16'h0100, 16'hFFFF};
        logic [15:0] bs  [3] = '{16'h0034, 16'h0100, 16'hFFFF};
        logic [15:0] res [3] = '{16'h03A8, 16'h0000, 16'h0001};
        logic [3:0]  flg [3] = '{4'b0010, 4'b0100, 4'b0010};
        int cyc, low;
        for (int i = 0; i < 3; i++) begin
            issue(3'b110, as[i], bs[i]);
            wait_done(cyc, low);
            total++; if (cyc !== 17) begin bad++; $display("FAIL mul_latency[%0d] got=%0d want=17", i, cyc); end
            total++; if (low !== 17) begin bad++; $display("FAIL mul_in_ready_low[%0d] got=%0d want=17", i, low); end
            total++; if (bus.alu_out !== res[i]) begin bad++; $display("FAIL mul_result[%0d] got=%h want=%h", i, bus.alu_out, res[i]); end
            total++; if ({bus.n_out, bus.z_out, bus.p_out, bus.c_out} !== flg[i]) begin bad++; $display("FAIL mul_flags[%0d] nzpc got=%b want=%b", i, {bus.n_out, bus.z_out, bus.p_out, bus.c_out}, flg[i]); end
            tick();
        end
    endtask

    task automatic test_sra();
        logic [15:0] as  [3] = '{16'h8000, 16'h1234, 16'h7000};
        logic [15:0] bs  [3] = '{16'h0004, 16'h0000, 16'hFFF3};
        logic [15:0] res [3] = '{16'hF800, 16'h1234, 16'h0E00};
        logic [3:0]  flg [3] = '{4'b1000, 4'b0010, 4'b0010};
        int          lat [3] = '{5, 1, 4};
        int cyc, low;
        for (int i = 0; i < 3; i++) begin
            issue(3'b111, as[i], bs[i]);
            wait_done(cyc, low);
            total++; if (cyc !== lat[i]) begin bad++; $display("FAIL sra_latency[%0d] got=%0d want=%0d", i, cyc, lat[i]); end
            total++; if (bus.alu_out !== res[i]) begin bad++; $display("FAIL sra_result[%0d] got=%h want=%h", i, bus.alu_out, res[i]); end
            total++; if ({bus.n_out, bus.z_out, bus.p_out, bus.c_out} !== flg[i]) begin bad++; $display("FAIL sra_flags[%0d] nzpc got=%b want=%b", i, {bus.n_out, bus.z_out, bus.p_out, bus.c_out}, flg[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int cyc, low;
        bus.out_ready = 1'b0;
        issue(3'b010, 16'h00FF, 16'h0000);
        wait_done(cyc, low);
        total++; if (cyc !== 1) begin bad++; $display("FAIL bp_latency got=%0d want=1", cyc); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a_in     = 16'(i * 16'h1111);
            bus.b_in     = ~16'(i);
            bus.aluk     = 3'b000;
            tick();
            total++; if ({bus.alu_out, bus.n_out, bus.in_ready, bus.out_valid} !== {16'hFF00, 3'b101}) begin bad++; $display("FAIL bp_hold[%0d] alu/n/ir/ov got=%h/%b%b%b want=ff00/101", i, bus.alu_out, bus.n_out, bus.in_ready, bus.out_valid); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL bp_release ov/ir got=%b want=01", {bus.out_valid, bus.in_ready}); end
        total++; if (bus.alu_out !== 16'hFF00) begin bad++; $display("FAIL bp_keep got=%h want=ff00", bus.alu_out); end
    endtask

    task automatic test_reset_mid_op();
        int cyc, low;
        issue(3'b110, 16'h0012, 16'h0034);
        total++; if ({bus.alu_out, bus.n_out, bus.out_valid} !== {16'hFF00, 2'b10}) begin bad++; $display("FAIL busy_hold alu/n/ov got=%h/%b%b want=ff00/10", bus.alu_out, bus.n_out, bus.out_valid); end
        repeat (7) tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL busy_cycle8_ov got=%b want=0", bus.out_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL midreset_hs ov/ir got=%b want=01", {bus.out_valid, bus.in_ready}); end
        total++; if ({bus.alu_out, bus.n_out, bus.z_out, bus.p_out, bus.c_out} !== {16'h0000, 4'b0100}) begin bad++; $display("FAIL midreset_out alu/nzpc got=%h/%b want=0000/0100", bus.alu_out, {bus.n_out, bus.z_out, bus.p_out, bus.c_out}); end
        issue(3'b000, 16'h0002, 16'h0003);
        wait_done(cyc, low);
        total++; if (cyc !== 1) begin bad++; $display("FAIL post_reset_latency got=%0d want=1", cyc); end
        total++; if ({bus.alu_out, bus.n_out, bus.z_out, bus.p_out, bus.c_out} !== {16'h0005, 4'b0010}) begin bad++; $display("FAIL post_reset_add alu/nzpc got=%h/%b want=0005/0010", bus.alu_out, {bus.n_out, bus.z_out, bus.p_out, bus.c_out}); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.aluk     = 3'b000;
        bus.a_in     = 16'h0001;
        bus.b_in     = 16'h0001;
        bus.in_valid = 1'b1;
        tick();
        total++; if ({bus.alu_out, bus.out_valid, bus.in_ready} !== {16'h0002, 2'b10}) begin bad++; $display("FAIL b2b_first alu/ov/ir got=%h/%b%b want=0002/10", bus.alu_out, bus.out_valid, bus.in_ready); end
        bus.a_in = 16'h0002;
        tick();
        total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL b2b_gap ov/ir got=%b want=01", {bus.out_valid, bus.in_ready}); end
        tick();
        bus.in_valid = 1'b0;
        total++; if ({bus.alu_out, bus.out_valid} !== {16'h0003, 1'b1}) begin bad++; $display("FAIL b2b_second alu/ov got=%h/%b want=0003/1", bus.alu_out, bus.out_valid); end
        tick();
        total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL b2b_idle ov/ir got=%b want=01", {bus.out_valid, bus.in_ready}); end
    endtask

    initial begin
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.aluk      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        test_reset();
        test_single();
        test_mul();
        test_sra();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
